// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8N1 serial transmitter for the analyzer's inverted-polarity line.
//
// Each accepted request sends a 10-bit frame, LSB first, with every bit held
// for BAUD_DIV clocks. Line levels are inverted relative to a standard UART:
// idle = 0, start = 1, data bits inverted, stop = 0.
//
// Optional feature macro: UART_TX_FIFO_EN
//   undefined : no buffering; tx_full mirrors tx_busy.
//   defined   : FIFO_DEPTH-entry byte FIFO in front of the serializer.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   trmt      in   one-cycle send request, paired with tx_data
//   tx_data   in   [7:0] byte to send
//   clr_done  in   clears tx_done
//   TX        out  serial line (registered)
//   tx_busy   out  frame in progress
//   tx_full   out  a request in this cycle would be ignored
//   tx_done   out  sticky: last frame completed
//   fsm_state out  current FSM state (0 = idle, 1 = transmitting)
//
// Handshake: trmt/tx_data form a one-cycle request. It is taken in the cycle
// it is high if tx_full is low (with the FIFO, also when the FIFO is full but
// is being popped in that same cycle); otherwise it is dropped silently.
module uart_tx_frame #(
  parameter int BAUD_DIV   = 34,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  input  logic       clr_done,
  output logic       TX,
  output logic       tx_busy,
  output logic       tx_full,
  output logic       tx_done,
  output logic       fsm_state
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LOAD = CW'(BAUD_DIV - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_TX   = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [9:0]     shift_reg;
  logic [CW-1:0]  baud_cnt;
  logic [3:0]     bit_cnt;
  logic           tx_q;
  logic           done_q;

  logic           load;
  logic [7:0]     load_data;
  logic           queue_empty;
  logic           shift;
  logic           last_shift;

  assign shift      = (state == S_TX) && (baud_cnt == '0);
  // The tenth shift ends the frame: the stop bit has then been held BAUD_DIV clocks.
  assign last_shift = shift && (bit_cnt == 4'd9);

`ifdef UART_TX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          fifo_full;
  logic          push;
  logic          pop;

  assign fifo_full   = (count == (AW + 1)'(FIFO_DEPTH));
  assign queue_empty = (count == '0);
  // The serializer drains the FIFO whenever it is idle, which leaves exactly
  // one idle clock between consecutive frames.
  assign pop         = (state == S_IDLE) && !queue_empty;
  // A full FIFO still accepts a byte in the cycle it is popped.
  assign push        = trmt && (!fifo_full || pop);
  assign load        = pop;
  assign load_data   = mem[rd_ptr];
  assign tx_full     = fifo_full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  assign queue_empty = 1'b1;
  assign load        = (state == S_IDLE) && trmt;
  assign load_data   = tx_data;
  assign tx_full     = (state == S_TX);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load)       state_nxt = S_TX;
      S_TX:    if (last_shift) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: shift register, bit timing, registered line output.
  // The line flop is loaded with the same value that becomes shift_reg[0],
  // so TX shows the start bit in the cycle after the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      tx_q      <= 1'b0;
    end else if (load) begin
      shift_reg <= {1'b0, ~load_data, 1'b1};
      baud_cnt  <= BAUD_LOAD;
      bit_cnt   <= '0;
      tx_q      <= 1'b1;
    end else if (shift) begin
      shift_reg <= {1'b0, shift_reg[9:1]};
      baud_cnt  <= BAUD_LOAD;
      bit_cnt   <= bit_cnt + 4'd1;
      tx_q      <= last_shift ? 1'b0 : shift_reg[1];
    end else if (state == S_TX) begin
      baud_cnt  <= baud_cnt - 1'b1;
    end
  end

  // Sticky completion flag: set wins over clr_done; a new frame clears it.
  // With the FIFO, it is only set once the queue has drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else if (last_shift && queue_empty) begin
      done_q <= 1'b1;
    end else if (load || clr_done) begin
      done_q <= 1'b0;
    end
  end

  assign TX        = tx_q;
  assign tx_busy   = (state == S_TX);
  assign tx_done   = done_q;
  assign fsm_state = state;

endmodule
